// File: rtl/lc3_pkg.sv
// Shared LC3 register-file types and constants.
// Data width, address width, NZP flags, responder state.
package lc3_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 3;

  typedef struct packed {
    logic n;
    logic z;
    logic p;
  } nzp_t;

  localparam nzp_t NZP_RESET = 3'b010;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } rf_state_t;

endpackage

// File: rtl/lc3_nzp_gen.sv
// Condition-code generator: value -> {N,Z,P}.
// Ports: i_data (DATA_W) in, o_nzp (nzp_t) out.
module lc3_nzp_gen
  import lc3_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic [W-1:0] i_data,
  output nzp_t         o_nzp
);

  always_comb begin
    o_nzp = 3'b001;
    unique case (1'b1)
      i_data[W-1]:      o_nzp = 3'b100;
      (i_data == '0):   o_nzp = 3'b010;
      default:          o_nzp = 3'b001;
    endcase
  end

endmodule

// File: rtl/lc3_regfile_server.sv
// LC3 register file with read-request responder and NZP codes.
// Ports: clock/reset, Data_req/addr/dout/complete_data, wb_*, psr_nzp.
module lc3_regfile_server #(
  parameter  int DATA_W   = 16,
  parameter  int NUM_REGS = 8,
  parameter  int READ_LAT = 1,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              Data_req,
  input  logic [AW-1:0]     Data_addr,
  output logic              req_ready,
  output logic [DATA_W-1:0] Data_dout,
  output logic              complete_data,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [2:0]        psr_nzp
);

  import lc3_pkg::*;

  localparam logic [3:0] LAT_M1 = 4'(READ_LAT - 1);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  rf_state_t         r_state;
  logic [3:0]        r_cnt;
  logic [AW-1:0]     r_addr;
  logic [DATA_W-1:0] r_dout;
  logic              r_cpl;
  nzp_t              r_nzp;

  logic              w_cap;
  logic              w_ready;
  logic              w_accept;
  logic [DATA_W-1:0] w_cap_data;
  nzp_t              w_nzp;

  lc3_nzp_gen #(
    .W (DATA_W)
  ) u_nzp (
    .i_data (wb_data),
    .o_nzp  (w_nzp)
  );

  assign w_cap    = (r_state == WAIT) && (r_cnt == 4'd0);
  assign w_ready  = (r_state == IDLE) || w_cap;
  assign w_accept = Data_req && w_ready;

  // A write landing on the capture edge must be seen by the read.
  assign w_cap_data = (wb_en && (wb_addr == r_addr))
                    ? wb_data : r_regs[r_addr];

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_dout  <= '0;
      r_cpl   <= 1'b0;
      r_nzp   <= NZP_RESET;
    end else begin
      if (wb_en) begin
        r_regs[wb_addr] <= wb_data;
        r_nzp           <= w_nzp;
      end
      r_cpl <= 1'b0;
      if (w_cap) begin
        r_dout <= w_cap_data;
        r_cpl  <= 1'b1;
      end
      if (w_accept) begin
        r_addr  <= Data_addr;
        r_cnt   <= LAT_M1;
        r_state <= WAIT;
      end else if (w_cap) begin
        r_state <= IDLE;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  assign req_ready     = w_ready;
  assign Data_dout     = r_dout;
  assign complete_data = r_cpl;
  assign psr_nzp       = r_nzp;

endmodule
